multi_led_blink: RTL and testbench

MULTI_LED_BLINK -- requirements
Module: multi_led_blink

---
 rtl/multi_led_blink.sv | 130 +++++++++++++
 tb/tb_multi_led_blink.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multi_led_blink.sv
// multi_led_blink: independent per-channel LED sequencers (off/on/blink/burst) sharing one ms prescaler
module multi_led_blink #(
    parameter int CH           = 4,
    parameter int BITS         = 16,
    parameter int TICKS_PER_MS = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH-1:0]        load,
    input  logic [2*CH-1:0]      mode,
    input  logic [BITS*CH-1:0]   onMs,
    input  logic [BITS*CH-1:0]   offMs,
    input  logic [BITS*CH-1:0]   burstCount,
    output logic [CH-1:0]        led,
    output logic [CH-1:0]        busy,
    output logic [CH-1:0]        done
);
    localparam int PW = $clog2(TICKS_PER_MS);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ON_PH   = 2'd1;
    localparam logic [1:0] OFF_PH  = 2'd2;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BURST = 2'd3;

    logic [PW-1:0]   pre_q, pre_d;
    logic            ms_tick;
    logic [1:0]      st_q [CH];
    logic [1:0]      st_d [CH];
    logic [1:0]      md_q [CH];
    logic [1:0]      md_d [CH];
    logic [BITS-1:0] on_q [CH];
    logic [BITS-1:0] on_d [CH];
    logic [BITS-1:0] off_q [CH];
    logic [BITS-1:0] off_d [CH];
    logic [BITS-1:0] ph_q [CH];
    logic [BITS-1:0] ph_d [CH];
    logic [BITS-1:0] rem_q [CH];
    logic [BITS-1:0] rem_d [CH];
    logic [CH-1:0]   led_q, led_d, busy_q, busy_d, done_q, done_d;

    // a zero-length phase behaves as one millisecond
    function automatic logic [BITS-1:0] last_ms(input logic [BITS-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    // free-running millisecond prescaler, never disturbed by load
    always_comb begin
        ms_tick = (pre_q == PW'(TICKS_PER_MS - 1));
        pre_d   = ms_tick ? '0 : pre_q + PW'(1);
    end

    // per-channel sequencer: load has priority, otherwise phases advance on ms ticks
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            st_d[i]   = st_q[i];
            md_d[i]   = md_q[i];
            on_d[i]   = on_q[i];
            off_d[i]  = off_q[i];
            ph_d[i]   = ph_q[i];
            rem_d[i]  = rem_q[i];
            led_d[i]  = led_q[i];
            busy_d[i] = busy_q[i];
            done_d[i] = 1'b0;
            if (load[i]) begin
                md_d[i]   = mode[2*i +: 2];
                on_d[i]   = onMs[BITS*i +: BITS];
                off_d[i]  = offMs[BITS*i +: BITS];
                ph_d[i]   = '0;
                rem_d[i]  = (mode[2*i +: 2] == M_BURST) ? burstCount[BITS*i +: BITS] : rem_q[i];
                done_d[i] = (mode[2*i +: 2] == M_BURST) && (burstCount[BITS*i +: BITS] == '0);
                busy_d[i] = mode[2*i+1] && !done_d[i];
                st_d[i]   = busy_d[i] ? ON_PH : IDLE;
                led_d[i]  = busy_d[i] || (mode[2*i +: 2] == M_ON);
            end else if (ms_tick && st_q[i] != IDLE) begin
                if (ph_q[i] != last_ms(st_q[i] == ON_PH ? on_q[i] : off_q[i])) begin
                    ph_d[i] = ph_q[i] + 1'b1;
                end else if (st_q[i] == ON_PH) begin
                    ph_d[i]  = '0;
                    st_d[i]  = OFF_PH;
                    led_d[i] = 1'b0;
                end else if (md_q[i] == M_BURST && rem_q[i] == BITS'(1)) begin
                    ph_d[i]   = '0;
                    rem_d[i]  = '0;
                    st_d[i]   = IDLE;
                    led_d[i]  = 1'b0;
                    busy_d[i] = 1'b0;
                    done_d[i] = 1'b1;
                end else begin
                    ph_d[i]  = '0;
                    rem_d[i] = (md_q[i] == M_BURST) ? rem_q[i] - 1'b1 : rem_q[i];
                    st_d[i]  = ON_PH;
                    led_d[i] = 1'b1;
                end
            end
        end
    end

    // state registers, all cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            led_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < CH; i++) begin
                st_q[i]  <= IDLE;
                md_q[i]  <= '0;
                on_q[i]  <= '0;
                off_q[i] <= '0;
                ph_q[i]  <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
            st_q   <= st_d;
            md_q   <= md_d;
            on_q   <= on_d;
            off_q  <= off_d;
            ph_q   <= ph_d;
            rem_q  <= rem_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_multi_led_blink.sv
// tb_multi_led_blink: randomized scoreboard bench against a tick-count reference model
module tb_multi_led_blink;
    localparam int CH = 4;
    localparam int BITS = 16;
    localparam int T = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [CH-1:0]       load = '0;
    logic [2*CH-1:0]     mode = '0;
    logic [BITS*CH-1:0]  onMs = '0;
    logic [BITS*CH-1:0]  offMs = '0;
    logic [BITS*CH-1:0]  burstCount = '0;
    logic [CH-1:0]       led, busy, done;

    always #5 clk = ~clk;

    multi_led_blink #(.CH(CH), .BITS(BITS), .TICKS_PER_MS(T)) dut (
        .clk(clk), .reset(reset), .load(load), .mode(mode), .onMs(onMs),
        .offMs(offMs), .burstCount(burstCount), .led(led), .busy(busy), .done(done)
    );

    int total = 0;
    int bad = 0;
    logic [3*CH-1:0] sb[$];

    // model: n = rising edges since reset release; each channel remembers its
    // load edge, config and the number of ms ticks m seen since that load
    int     n = 0;
    bit     act[CH];
    int     md[CH];
    longint a[CH], b[CH], k[CH], m[CH], ld_at[CH];

    task automatic check(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, want);
        end
    endtask

    function automatic logic [3*CH-1:0] expect_now();
        logic [CH-1:0] l, bz, d;
        longint p;
        l = '0; bz = '0; d = '0;
        for (int i = 0; i < CH; i++) begin
            p = a[i] + b[i];
            if (act[i]) begin
                if (md[i] == 1) l[i] = 1'b1;
                else if (md[i] == 2) begin
                    l[i] = (m[i] % p) < a[i];
                    bz[i] = 1'b1;
                end else if (md[i] == 3) begin
                    if (k[i] == 0) d[i] = (n == ld_at[i]);
                    else if (m[i] < k[i] * p) begin
                        l[i] = (m[i] % p) < a[i];
                        bz[i] = 1'b1;
                    end else d[i] = (m[i] == k[i] * p) && (n % T == 0);
                end
            end
        end
        return {l, bz, d};
    endfunction

    task automatic cfg(input int i, input int mdv, input int on, input int off, input int bc);
        mode[2*i +: 2] = mdv[1:0];
        onMs[BITS*i +: BITS] = on[BITS-1:0];
        offMs[BITS*i +: BITS] = off[BITS-1:0];
        burstCount[BITS*i +: BITS] = bc[BITS-1:0];
    endtask

    task automatic step(input logic [CH-1:0] ld);
        for (int i = 0; i < CH; i++)
            if (!ld[i]) cfg(i, $urandom, $urandom, $urandom, $urandom);
        load = ld;
        reset = 1'b1;
        n++;
        for (int i = 0; i < CH; i++) begin
            if (ld[i]) begin
                act[i] = 1'b1;
                md[i] = int'(mode[2*i +: 2]);
                a[i] = (onMs[BITS*i +: BITS] == 0) ? 1 : longint'(onMs[BITS*i +: BITS]);
                b[i] = (offMs[BITS*i +: BITS] == 0) ? 1 : longint'(offMs[BITS*i +: BITS]);
                k[i] = longint'(burstCount[BITS*i +: BITS]);
                m[i] = 0;
                ld_at[i] = n;
            end else if (n % T == 0) m[i]++;
        end
        sb.push_back(expect_now());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rst_step();
        reset = 1'b0;
        load = '0;
        #1;
        check("rst_led", led, '0);
        check("rst_busy", busy, '0);
        check("rst_done", done, '0);
        n = 0;
        for (int i = 0; i < CH; i++) act[i] = 1'b0;
        sb.push_back('0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // monitor: one scoreboard entry per rising edge, sampled just after it
    initial begin
        logic [3*CH-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("led", led, e[3*CH-1:2*CH]);
                check("busy", busy, e[2*CH-1:CH]);
                check("done", done, e[CH-1:0]);
            end
        end
    end

    initial begin
        logic [CH-1:0] ld;
        for (int i = 0; i < CH; i++) begin
            act[i] = 1'b0; md[i] = 0; a[i] = 1; b[i] = 1; k[i] = 0; m[i] = 0; ld_at[i] = 0;
        end
        #2;
        repeat (3) rst_step();
        repeat (1000) step('0);
        cfg(0, 2, 3, 2, 0);
        cfg(1, 3, 1, 1, 3);
        cfg(2, 3, 1, 1, 0);
        cfg(3, 1, 0, 0, 0);
        step(4'hF);
        repeat (100) step('0);
        cfg(0, 2, 3, 2, 0);
        step(4'h1);
        repeat (5) step('0);
        cfg(0, 0, 0, 0, 0);
        step(4'h1);
        repeat (20) step('0);
        for (int i = 0; i < CH; i++) cfg(i, 3, 2, 1, 3);
        step(4'hF);
        repeat (25) step('0);
        repeat (2) rst_step();
        repeat (60) step('0);
        for (int s = 0; s < 3000; s++) begin
            if (s == 1500) rst_step();
            ld = '0;
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    ld[i] = 1'b1;
                    cfg(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                        int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
                end
            end
            step(ld);
        end
        repeat (2) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
